// File: rtl/echo_wnd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : echo_wnd_sequencer_pkg
// Brief    : Shared acquisition types: sequencer FSM encoding, bus width default.
// Revision : 1.0
// ============================================================================
package echo_wnd_sequencer_pkg;

    localparam int c_DATABUS_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_ECHO   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/echo_wnd_sequencer_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module   : cycle_counter
// Brief    : Loadable down-counter with zero flag; exposes its next value.
// Revision : 1.0
// ============================================================================
module cycle_counter
    import echo_wnd_sequencer_pkg::*;
#(
    parameter int WIDTH = c_DATABUS_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_next,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // Saturates at zero so a stalled decrement never wraps.
    always_comb begin
        w_next = r_count;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            w_next = r_count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_next = w_next;
    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/echo_wnd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : echo_wnd_sequencer
// Brief    : Echo-train sequencer producing a per-period acquisition window.
// Revision : 1.0
// ============================================================================
module echo_wnd_sequencer
    import echo_wnd_sequencer_pkg::*;
#(
    parameter int DATABUS_WIDTH = c_DATABUS_WIDTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [DATABUS_WIDTH-1:0] INIT_DELAY,
    input  logic [DATABUS_WIDTH-1:0] ECHO_PERIOD,
    input  logic [DATABUS_WIDTH-1:0] WND_OFFSET,
    input  logic [DATABUS_WIDTH-1:0] WND_WIDTH,
    input  logic [DATABUS_WIDTH-1:0] ECHO_COUNT,
    output logic                     ACQ_WND,
    output logic [DATABUS_WIDTH-1:0] ECHO_IDX,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     CFG_ERR
);

    state_t                   r_state, w_state_nxt;
    logic [DATABUS_WIDTH-1:0] r_delay, r_period, r_offset, r_width, r_count;
    logic [DATABUS_WIDTH-1:0] r_idx, w_idx_nxt;
    logic                     r_acq, w_acq_nxt;
    logic                     r_cfg_err, w_cfg_err_nxt;

    logic                     w_start_req, w_cfg_ok, w_accept;
    logic [DATABUS_WIDTH:0]   w_wnd_end;
    logic [DATABUS_WIDTH-1:0] w_delay, w_period, w_offset, w_width, w_count;
    logic [DATABUS_WIDTH-1:0] w_wnd_hi, w_wnd_lo;

    logic                     w_ctr_load, w_ctr_dec, w_ctr_zero;
    logic [DATABUS_WIDTH-1:0] w_ctr_val, w_ctr_next;

    // ABORT in IDLE masks START entirely, including the config-error pulse.
    assign w_start_req   = (r_state == ST_IDLE) && START && !ABORT;
    assign w_wnd_end     = {1'b0, WND_OFFSET} + {1'b0, WND_WIDTH};
    assign w_cfg_ok      = (ECHO_PERIOD != '0) && (WND_WIDTH != '0) && (ECHO_COUNT != '0)
                           && (w_wnd_end <= {1'b0, ECHO_PERIOD});
    assign w_accept      = w_start_req && w_cfg_ok;
    assign w_cfg_err_nxt = w_start_req && !w_cfg_ok;

    // Live inputs in the accept cycle, latched copies while the train runs.
    assign w_delay  = w_accept ? INIT_DELAY  : r_delay;
    assign w_period = w_accept ? ECHO_PERIOD : r_period;
    assign w_offset = w_accept ? WND_OFFSET  : r_offset;
    assign w_width  = w_accept ? WND_WIDTH   : r_width;
    assign w_count  = w_accept ? ECHO_COUNT  : r_count;

    // The period counter runs PERIOD-1 down to 0, so the window maps to a count range.
    assign w_wnd_hi = w_period - DATABUS_WIDTH'(1) - w_offset;
    assign w_wnd_lo = w_period - w_offset - w_width;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ctr_load  = 1'b0;
        w_ctr_val   = '0;
        w_ctr_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_idx_nxt  = '0;
                    w_ctr_load = 1'b1;
                    if (w_delay == '0) begin
                        w_state_nxt = ST_ECHO;
                        w_ctr_val   = w_period - DATABUS_WIDTH'(1);
                    end else begin
                        w_state_nxt = ST_INIT;
                        w_ctr_val   = w_delay - DATABUS_WIDTH'(1);
                    end
                end
            end
            ST_INIT: begin
                if (ABORT) begin
                    w_state_nxt = ST_IDLE;
                    w_ctr_load  = 1'b1;
                end else if (w_ctr_zero) begin
                    w_state_nxt = ST_ECHO;
                    w_ctr_load  = 1'b1;
                    w_ctr_val   = w_period - DATABUS_WIDTH'(1);
                end else begin
                    w_ctr_dec = 1'b1;
                end
            end
            ST_ECHO: begin
                if (ABORT) begin
                    w_state_nxt = ST_IDLE;
                    w_ctr_load  = 1'b1;
                end else if (w_ctr_zero) begin
                    if (r_idx == w_count - DATABUS_WIDTH'(1)) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_idx_nxt  = r_idx + DATABUS_WIDTH'(1);
                        w_ctr_load = 1'b1;
                        w_ctr_val  = w_period - DATABUS_WIDTH'(1);
                    end
                end else begin
                    w_ctr_dec = 1'b1;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_acq_nxt = (w_state_nxt == ST_ECHO)
                       && (w_ctr_next >= w_wnd_lo) && (w_ctr_next <= w_wnd_hi);

    cycle_counter #(
        .WIDTH (DATABUS_WIDTH)
    ) u_cycle_counter (
        .clk        (CLK),
        .rst        (RESET),
        .i_load     (w_ctr_load),
        .i_load_val (w_ctr_val),
        .i_dec      (w_ctr_dec),
        .o_next     (w_ctr_next),
        .o_zero     (w_ctr_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_acq     <= 1'b0;
            r_cfg_err <= 1'b0;
            r_delay   <= '0;
            r_period  <= '0;
            r_offset  <= '0;
            r_width   <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_acq     <= w_acq_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            if (w_accept) begin
                r_delay  <= INIT_DELAY;
                r_period <= ECHO_PERIOD;
                r_offset <= WND_OFFSET;
                r_width  <= WND_WIDTH;
                r_count  <= ECHO_COUNT;
            end
        end
    end

    assign ACQ_WND  = r_acq;
    assign ECHO_IDX = r_idx;
    assign BUSY     = (r_state == ST_INIT) || (r_state == ST_ECHO);
    assign DONE     = (r_state == ST_FINISH);
    assign CFG_ERR  = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/echo_wnd_sequencer.md
ECHO_WND_SEQUENCER -- requirements
Module: echo_wnd_sequencer

Interface
REQ-001 SHALL have parameter DATABUS_WIDTH, default 32, width of all timing/count inputs.
REQ-002 SHALL have ports:
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to run an echo train.
- ABORT  in  1  terminate a running train.
- INIT_DELAY  in  DATABUS_WIDTH  cycles from START acceptance to echo 0 start.
- ECHO_PERIOD  in  DATABUS_WIDTH  cycles per echo period.
- WND_OFFSET  in  DATABUS_WIDTH  window start offset within a period, in cycles.
- WND_WIDTH  in  DATABUS_WIDTH  window length, in cycles.
- ECHO_COUNT  in  DATABUS_WIDTH  number of echoes per train.
- ACQ_WND  out  1  acquisition window, drives the ADC window generator's ACQ_WND input.
- ECHO_IDX  out  DATABUS_WIDTH  index of the current echo.
- BUSY  out  1  train in progress.
- DONE  out  1  one-cycle pulse on normal completion.
- CFG_ERR  out  1  one-cycle pulse when START is rejected.

Function
REQ-003 SHALL latch all five timing inputs when START is accepted; later input changes SHALL NOT affect the running train.
REQ-004 SHALL implement FSM states IDLE, INIT, ECHO, FINISH; IDLE->INIT on START accepted; INIT->ECHO after INIT_DELAY cycles; ECHO->FINISH after ECHO_COUNT periods; FINISH->IDLE after one cycle.
REQ-005 SHALL accept START only in IDLE; START while BUSY SHALL be ignored.
REQ-006 START accepted at cycle t SHALL raise BUSY at t+1; echo period k (0-based) SHALL begin at cycle t+1+INIT_DELAY+k*ECHO_PERIOD; INIT_DELAY=0 SHALL enter ECHO directly.
REQ-007 ACQ_WND SHALL be registered and high exactly for period-relative cycles WND_OFFSET through WND_OFFSET+WND_WIDTH-1 of each echo period, low otherwise.
REQ-008 ECHO_IDX SHALL be 0 from acceptance, increment at each echo period boundary, and hold ECHO_COUNT-1 after completion until next acceptance.
REQ-009 DONE SHALL pulse at cycle t+1+INIT_DELAY+ECHO_COUNT*ECHO_PERIOD; BUSY SHALL be low in that same cycle.
REQ-010 START with ECHO_PERIOD=0, WND_WIDTH=0, ECHO_COUNT=0, or WND_OFFSET+WND_WIDTH>ECHO_PERIOD SHALL be rejected: CFG_ERR pulses at t+1, BUSY stays low, no DONE.
REQ-011 WND_OFFSET+WND_WIDTH SHALL be computed in DATABUS_WIDTH+1 bits; no wrap-around.
REQ-012 ABORT in cycle a while BUSY SHALL force ACQ_WND=0 and BUSY=0 at a+1, return to IDLE, no DONE.
REQ-013 START and ABORT together in IDLE: ABORT SHALL win, START ignored.
REQ-014 ABORT in FINISH SHALL NOT suppress the DONE pulse.

Reset
REQ-015 RESET high at a rising CLK edge SHALL force IDLE, ACQ_WND=0, BUSY=0, DONE=0, CFG_ERR=0, ECHO_IDX=0, latched registers=0, at any time including mid-train.
REQ-016 RESET SHALL override START and ABORT.

Structure
REQ-017 FSM state encoding and DATABUS_WIDTH default SHALL live in the shared acquisition package.
REQ-018 A sub-module cycle_counter (load, count-down, zero flag) SHALL be used for both init delay and period counting.

Verification
REQ-019 D=3,P=20,OFF=5,W=10,N=3, START at cycle 0 -> ACQ_WND high cycles 9-18, 29-38, 49-58; DONE at 64; BUSY 1-63.
REQ-020 D=0,P=4,OFF=0,W=4,N=2 -> ACQ_WND continuously high cycles 1-8; DONE at 9.
REQ-021 OFF=15,W=10,P=20 -> CFG_ERR at cycle 1, BUSY never high; likewise N=0.
REQ-022 Scenario REQ-019 with ABORT at cycle 32 -> ACQ_WND and BUSY low from 33, no DONE; new START at 40 runs full train.
REQ-023 Scenario REQ-019 with RESET at cycle 30 -> all outputs 0 from 31; START at cycle 20 ignored (BUSY); inputs changed at cycle 10 do not alter windows.
